// File: rtl/uart_pkg.sv
// Shared UART FIFO definitions: read-mode constants, default geometry and a
// constant-foldable ceil(log2) helper for sizing occupancy counters.
package uart_pkg;

    localparam int FIFO_MODE_REG  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    localparam int DEF_DW = 8;
    localparam int DEF_AW = 10;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/uart_fifo_ram.sv
// Simple dual-port storage: synchronous write, synchronous read, no reset.
// A same-address read and write in one cycle returns the old word.
module uart_fifo_ram #(
    parameter int DW = 8,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd,
    input  logic          re,
    input  logic [AW-1:0] ra,
    output logic [DW-1:0] rq
);

    (* ram_style = "block" *) logic [DW-1:0] mem [0:(1 << AW)-1];

    always_ff @(posedge clk) begin
        if (we) mem[wa] <= wd;
        if (re) rq <= mem[ra];
    end

endmodule

// File: rtl/uart_fifo_param.sv
// Parametrised UART data FIFO: pointer/count/flag control, optional
// first-word-fall-through output register, sticky overflow/underflow.
module uart_fifo_param
    import uart_pkg::*;
#(
    parameter int DW     = DEF_DW,
    parameter int AW     = DEF_AW,
    parameter int AF_LVL = 1020,
    parameter int AE_LVL = 4,
    parameter int FWFT   = FIFO_MODE_REG
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic          almost_empty,
    output logic [AW:0]   count,
    output logic          ovf,
    output logic          udf
);

    localparam int DEPTH  = 1 << AW;
    localparam int CW     = clog2(DEPTH + 1);
    localparam bit AF_RST = (0 >= AF_LVL);
    localparam bit AE_RST = (0 <= AE_LVL);

    logic [AW:0]   wp, rp;
    logic [CW-1:0] cnt_q, cnt_nxt;
    logic [DW-1:0] ram_q;
    logic          pend;          // RAM read in flight / prefetched word held in ram_q
    logic          rd_ok, wr_ok, ram_re, q_move, pend_nxt, rv_nxt;

    always_comb begin
        rd_ok   = rd_en & ((FWFT == FIFO_MODE_FWFT) ? rd_valid : ~empty);
        wr_ok   = wr_en & (~full | rd_ok);
        cnt_nxt = cnt_q + CW'(wr_ok) - CW'(rd_ok);
        if (FWFT == FIFO_MODE_FWFT) begin
            // Keep one word staged in ram_q so a pop refills rd_data next edge.
            q_move   = pend & (~rd_valid | rd_ok);
            ram_re   = (wp != rp) & (~pend | q_move);
            pend_nxt = ram_re | (pend & ~q_move);
            rv_nxt   = q_move | (rd_valid & ~rd_ok);
        end else begin
            q_move   = pend;
            ram_re   = rd_ok;
            pend_nxt = rd_ok;
            rv_nxt   = pend;
        end
    end

    uart_fifo_ram #(.DW(DW), .AW(AW)) u_ram (
        .clk (clk),
        .we  (wr_ok),
        .wa  (wp[AW-1:0]),
        .wd  (wr_data),
        .re  (ram_re),
        .ra  (rp[AW-1:0]),
        .rq  (ram_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp <= '0; rp <= '0; cnt_q <= '0;
            full <= 1'b0; empty <= 1'b1;
            almost_full <= AF_RST; almost_empty <= AE_RST;
            ovf <= 1'b0; udf <= 1'b0;
            pend <= 1'b0; rd_valid <= 1'b0; rd_data <= '0;
        end else if (clr) begin
            wp <= '0; rp <= '0; cnt_q <= '0;
            full <= 1'b0; empty <= 1'b1;
            almost_full <= AF_RST; almost_empty <= AE_RST;
            ovf <= 1'b0; udf <= 1'b0;
            pend <= 1'b0; rd_valid <= 1'b0; rd_data <= '0;
        end else begin
            wp           <= wp + (AW+1)'(wr_ok);
            rp           <= rp + (AW+1)'(ram_re);
            cnt_q        <= cnt_nxt;
            full         <= (int'(cnt_nxt) == DEPTH);
            empty        <= (cnt_nxt == '0);
            almost_full  <= (int'(cnt_nxt) >= AF_LVL);
            almost_empty <= (int'(cnt_nxt) <= AE_LVL);
            ovf          <= ovf | (wr_en & ~wr_ok);
            udf          <= udf | (rd_en & ~rd_ok);
            pend         <= pend_nxt;
            rd_valid     <= rv_nxt;
            if (q_move) rd_data <= ram_q;
        end
    end

    assign count = cnt_q;

endmodule

// File: tb/tb_uart_fifo_param.sv
// Directed bench for uart_fifo_param: registered-read instance checked by a
// vector table plus a queue model, and a FWFT instance checked by hand.
module tb_uart_fifo_param;

    logic       clk, rst_n;
    logic       clr, wr_en, rd_en;
    logic [7:0] wr_data, rd_data;
    logic       rd_valid, full, empty, almost_full, almost_empty, ovf, udf;
    logic [4:0] count;

    logic       f_clr, f_wr, f_rd;
    logic [7:0] f_din, f_rdat;
    logic       f_rv, f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
    logic [4:0] f_count;

    uart_fifo_param #(.DW(8), .AW(4), .AF_LVL(14), .AE_LVL(2), .FWFT(0)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .full(full),
        .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count), .ovf(ovf), .udf(udf)
    );

    uart_fifo_param #(.DW(8), .AW(4), .AF_LVL(14), .AE_LVL(2), .FWFT(1)) dut_f (
        .clk(clk), .rst_n(rst_n), .clr(f_clr), .wr_en(f_wr), .wr_data(f_din),
        .rd_en(f_rd), .rd_data(f_rdat), .rd_valid(f_rv), .full(f_full),
        .empty(f_empty), .almost_full(f_af), .almost_empty(f_ae),
        .count(f_count), .ovf(f_ovf), .udf(f_udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // queue model of the registered-read FIFO
    logic [7:0] m_q[$];
    logic       m_ovf, m_udf, m_s1v, m_rv;
    logic [7:0] m_s1d, m_rd;

    typedef struct {
        logic       clr, wr, rd;
        logic [7:0] din;
        logic [4:0] cnt;
        logic       emp, ful, ud, rv;
        logic [7:0] rdat;
    } vec_t;
    vec_t tbl[9];

    task automatic chk(input string tag, input string fld, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %0h expected %0h", tag, fld, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic m_reset();
        m_q.delete();
        m_ovf = 0; m_udf = 0; m_s1v = 0; m_rv = 0; m_s1d = 8'h00; m_rd = 8'h00;
    endtask

    task automatic check_all(input string tag);
        int c;
        c = m_q.size();
        chk(tag, "count", count, c);
        chk(tag, "full", full, c == 16);
        chk(tag, "empty", empty, c == 0);
        chk(tag, "almost_full", almost_full, c >= 14);
        chk(tag, "almost_empty", almost_empty, c <= 2);
        chk(tag, "ovf", ovf, m_ovf);
        chk(tag, "udf", udf, m_udf);
        chk(tag, "rd_valid", rd_valid, m_rv);
        chk(tag, "rd_data", rd_data, m_rd);
    endtask

    task automatic op(input string tag, input bit wr, input bit rd, input logic [7:0] din);
        bit rok, wok;
        rok = rd && (m_q.size() != 0);
        wok = wr && (m_q.size() != 16 || rok);
        wr_en = wr; rd_en = rd; wr_data = din;
        step();
        wr_en = 0; rd_en = 0;
        m_rv = m_s1v;
        if (m_s1v) m_rd = m_s1d;
        m_s1v = rok;
        if (rok) m_s1d = m_q.pop_front();
        if (wok) m_q.push_back(din);
        if (wr && !wok) m_ovf = 1;
        if (rd && !rok) m_udf = 1;
        check_all(tag);
    endtask

    task automatic mclr(input string tag);
        clr = 1; wr_en = 1; rd_en = 1; wr_data = 8'hFF;
        step();
        clr = 0; wr_en = 0; rd_en = 0;
        m_reset();
        check_all(tag);
    endtask

    initial begin
        rst_n = 1; clr = 0; wr_en = 0; rd_en = 0; wr_data = 0;
        f_clr = 0; f_wr = 0; f_rd = 0; f_din = 0;
        m_reset();
        #2 rst_n = 0;
        #1 check_all("por");
        step(); step();
        rst_n = 1;
        step();
        check_all("por_rel");

        // clr, wr, rd, din, cnt, emp, ful, udf, rv, rdat
        tbl[0] = '{1'b0, 1'b1, 1'b0, 8'hA1, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 8'hB2, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 8'h00, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[3] = '{1'b0, 1'b0, 1'b0, 8'h00, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA1};
        tbl[4] = '{1'b0, 1'b1, 1'b1, 8'hC3, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA1};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hB2};
        tbl[6] = '{1'b0, 1'b0, 1'b1, 8'h00, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 8'hC3};
        tbl[7] = '{1'b0, 1'b1, 1'b1, 8'hD4, 5'd1, 1'b0, 1'b0, 1'b1, 1'b0, 8'hC3};
        tbl[8] = '{1'b1, 1'b1, 1'b1, 8'hE5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        for (int i = 0; i < 9; i++) begin
            string tg;
            tg = $sformatf("vec%0d", i);
            clr = tbl[i].clr; wr_en = tbl[i].wr; rd_en = tbl[i].rd; wr_data = tbl[i].din;
            step();
            clr = 0; wr_en = 0; rd_en = 0;
            chk(tg, "count", count, tbl[i].cnt);
            chk(tg, "empty", empty, tbl[i].emp);
            chk(tg, "full", full, tbl[i].ful);
            chk(tg, "udf", udf, tbl[i].ud);
            chk(tg, "ovf", ovf, 1'b0);
            chk(tg, "rd_valid", rd_valid, tbl[i].rv);
            chk(tg, "rd_data", rd_data, tbl[i].rdat);
        end
        mclr("t0_clr");

        // reset asserted with a read in flight
        op("t1_w", 1, 0, 8'h11); op("t1_w", 1, 0, 8'h22); op("t1_w", 1, 0, 8'h33);
        op("t1_r", 0, 1, 8'h00); op("t1_r", 0, 1, 8'h00);
        #2 rst_n = 0;
        #1 m_reset();
        check_all("t1_async");
        @(posedge clk); #1 rst_n = 1;
        step();
        check_all("t1_rel");
        op("t1_wa5", 1, 0, 8'hA5);
        op("t1_ra5", 0, 1, 8'h00);
        op("t1_lat", 0, 0, 8'h00);
        chk("t1", "a5_data", rd_data, 8'hA5);
        chk("t1", "a5_valid", rd_valid, 1'b1);

        // fill to full, overflow, drain in order
        for (int i = 0; i < 16; i++) op("t2_fill", 1, 0, 8'(i));
        op("t2_ovf", 1, 0, 8'hEE);
        for (int i = 0; i < 16; i++) op("t2_drain", 0, 1, 8'h00);
        op("t2_tail", 0, 0, 8'h00); op("t2_tail", 0, 0, 8'h00);
        mclr("t2_clr");

        // simultaneous write and read while full
        for (int i = 0; i < 16; i++) op("t3_fill", 1, 0, 8'h10 + 8'(i));
        op("t3_wr_rd", 1, 1, 8'h55);
        for (int i = 0; i < 16; i++) op("t3_drain", 0, 1, 8'h00);
        op("t3_tail", 0, 0, 8'h00); op("t3_tail", 0, 0, 8'h00);
        chk("t3", "last_word", rd_data, 8'h55);

        // empty with write and read together, then clr
        op("t4_wr_rd", 1, 1, 8'h66);
        chk("t4", "udf", udf, 1'b1);
        mclr("t4_clr");

        // random interleave across several pointer wraps
        for (int i = 0; i < 120; i++) begin
            bit w, r;
            w = ($urandom_range(0, 99) < (i < 60 ? 70 : 50));
            r = ($urandom_range(0, 99) < (i < 60 ? 40 : 55));
            op("t5_rand", w, r, 8'($urandom));
        end

        // first-word-fall-through instance
        f_wr = 1; f_din = 8'h3C;
        step();
        f_wr = 0;
        chk("t6", "n_rv", f_rv, 1'b0);
        chk("t6", "n_cnt", f_count, 5'd1);
        step();
        chk("t6", "n1_rv", f_rv, 1'b0);
        step();
        chk("t6", "n2_rv", f_rv, 1'b1);
        chk("t6", "n2_data", f_rdat, 8'h3C);
        chk("t6", "n2_empty", f_empty, 1'b0);
        for (int i = 0; i < 8; i++) begin
            f_wr = 1; f_din = 8'h40 + 8'(i);
            step();
        end
        f_wr = 0;
        chk("t6", "fill_cnt", f_count, 5'd9);
        step(); step();
        chk("t6", "head_hold", f_rdat, 8'h3C);
        f_rd = 1;
        for (int k = 0; k < 10; k++) begin
            step();
            if (k < 8) begin
                chk("t6_pop", "rv", f_rv, 1'b1);
                chk("t6_pop", "data", f_rdat, 8'h40 + 8'(k));
                chk("t6_pop", "count", f_count, 5'(8 - k));
            end else begin
                chk("t6_pop", "rv_end", f_rv, 1'b0);
                chk("t6_pop", "count_end", f_count, 5'd0);
                chk("t6_pop", "empty_end", f_empty, 1'b1);
                chk("t6_pop", "udf", f_udf, (k == 9) ? 1'b1 : 1'b0);
            end
        end
        f_rd = 0;
        chk("t6", "ovf", f_ovf, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
